// File: rtl/irq_event_ctrl_pkg.sv
// Shared constants and types for the interrupt/event status block.
package irq_event_pkg;
    localparam logic [1:0] ADDR_PENDING  = 2'b00;
    localparam logic [1:0] ADDR_OVERFLOW = 2'b01;
    localparam logic [1:0] ADDR_MASKED   = 2'b10;
    localparam logic [1:0] ADDR_EVCOUNT  = 2'b11;

    localparam int EVCOUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;
endpackage

// File: rtl/irq_event_ctrl_if.sv
// Avalon-MM slave port for the status registers (fixed read latency 1).
interface irq_event_ctrl_if #(
    parameter int DATA_REG_BITS = 32
);
    logic [1:0]               address;
    logic                     read;
    logic                     write;
    logic [DATA_REG_BITS-1:0] writedata;
    logic [DATA_REG_BITS-1:0] readdata;
    logic                     readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/irq_event_ctrl_edge_detect.sv
// Per-source rising-edge detector; prev resets to 0 so a line high at reset release counts as a rise.
module irq_edge_detect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= level;
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/irq_event_ctrl.sv
// Sticky event capture, W1C status registers and a holdoff-limited level interrupt toward the HPS.
//   state   | meaning
//   IDLE    | irq low, waiting for a masked-in pending bit
//   ACTIVE  | irq high until no masked-in pending bit remains
//   HOLDOFF | irq low for HOLDOFF_CYCLES; pending work re-arms straight to ACTIVE
module irq_event_ctrl
    import irq_event_pkg::*;
#(
    parameter int DATA_REG_BITS  = 32,
    parameter int NUM_SOURCES    = 8,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SOURCES-1:0] event_in,
    input  logic [7:0]             mask,
    irq_event_ctrl_if.slave        bus,
    output logic                   irq
);
    localparam int HW      = $clog2(HOLDOFF_CYCLES + 1);
    localparam int EVSUM_W = EVCOUNT_W + 1;

    logic [NUM_SOURCES-1:0]   rise, pending, overflow, pend_clr, ovf_clr;
    logic [EVCOUNT_W-1:0]     evcount;
    logic [EVSUM_W-1:0]       ev_sum;
    logic [3:0]               rise_cnt;
    logic [DATA_REG_BITS-1:0] rd_mux;
    logic                     any, ev_clr;
    logic                     unused_bits;
    irq_state_t               state, state_nxt;
    logic [HW-1:0]            hold_cnt, hold_cnt_nxt;

    irq_edge_detect #(.WIDTH(NUM_SOURCES)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (event_in),
        .rise  (rise)
    );

    assign pend_clr = (bus.write && bus.address == ADDR_PENDING)  ? bus.writedata[NUM_SOURCES-1:0] : '0;
    assign ovf_clr  = (bus.write && bus.address == ADDR_OVERFLOW) ? bus.writedata[NUM_SOURCES-1:0] : '0;
    assign ev_clr   = bus.write && bus.address == ADDR_EVCOUNT;
    assign unused_bits = ^{bus.writedata, mask};

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_SOURCES; i++) rise_cnt = rise_cnt + 4'(rise[i]);
    end

    assign ev_sum = {1'b0, evcount} + EVSUM_W'(rise_cnt);

    // Set terms are ORed after the clear so a same-cycle rise always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
            evcount  <= '0;
        end else begin
            pending  <= (pending & ~pend_clr) | rise;
            overflow <= (overflow & ~ovf_clr) | (rise & pending);
            if (ev_clr)          evcount <= '0;
            else if (ev_sum[EVCOUNT_W]) evcount <= '1;
            else                 evcount <= ev_sum[EVCOUNT_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PENDING:  rd_mux = DATA_REG_BITS'(pending);
            ADDR_OVERFLOW: rd_mux = DATA_REG_BITS'(overflow);
            ADDR_MASKED:   rd_mux = DATA_REG_BITS'(pending & mask[NUM_SOURCES-1:0]);
            ADDR_EVCOUNT:  rd_mux = DATA_REG_BITS'(evcount);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) bus.readdata <= rd_mux;
        end
    end

    assign any = |(pending & mask[NUM_SOURCES-1:0]);

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE:    if (any) state_nxt = ACTIVE;
            ACTIVE:  if (!any) begin
                         state_nxt    = HOLDOFF;
                         hold_cnt_nxt = HW'(HOLDOFF_CYCLES - 1);
                     end
            HOLDOFF: if (hold_cnt == '0) state_nxt = any ? ACTIVE : IDLE;
                     else                hold_cnt_nxt = hold_cnt - HW'(1);
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            irq      <= (state_nxt == ACTIVE);
        end
    end
endmodule

// File: tb/tb_irq_event_ctrl.sv
// Directed bench for irq_event_ctrl: edge capture, W1C, holdoff timing, saturation and reset.
module tb_irq_event_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  event_in = '0;
    logic [7:0]  mask = '0;
    logic        irq;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        rv;

    irq_event_ctrl_if #(.DATA_REG_BITS(32)) bus_if ();

    irq_event_ctrl #(.DATA_REG_BITS(32), .NUM_SOURCES(8), .HOLDOFF_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .mask     (mask),
        .bus      (bus_if),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        @(negedge clk);
        bus_if.read = 1'b0;
        d = bus_if.readdata;
        v = bus_if.readdatavalid;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(negedge clk);
        bus_if.write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (bus_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", bus_if.readdatavalid); end
        checks++; if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_if.readdata); end
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a), rd, rv);
            checks++; if (rd !== 32'h0 || rv !== 1'b1) begin errors++; $display("FAIL reset_reg%0d got %h/%b want 0/1", a, rd, rv); end
        end
    endtask

    task automatic test_event_irq();
        mask = 8'h04;
        @(negedge clk) event_in = 8'h04;
        @(negedge clk) event_in = 8'h00;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_n1 got %b want 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_n2 got %b want 1", irq); end
        do_read(2'b00, rd, rv);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL pending_bit2 got %h want 4", rd); end
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL evcount_1 got %h want 1", rd); end
        do_read(2'b10, rd, rv);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL masked_bit2 got %h want 4", rd); end
    endtask

    task automatic test_holdoff();
        @(negedge clk);
        bus_if.address = 2'b00; bus_if.writedata = 32'h4; bus_if.write = 1'b1;
        @(negedge clk);
        bus_if.write = 1'b0; event_in = 8'h04;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_n1 got %b want 1", irq); end
        @(negedge clk) event_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL holdoff_low%0d got %b want 0", i, irq); end
            @(negedge clk);
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL holdoff_rearm got %b want 1", irq); end
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL evcount_2 got %h want 2", rd); end
        do_write(2'b00, 32'hFF);
        repeat (8) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear got %b want 0", irq); end
    endtask

    task automatic test_overflow();
        mask = 8'h00;
        @(negedge clk) event_in = 8'h20;
        @(negedge clk) event_in = 8'h00;
        @(negedge clk) event_in = 8'h20;
        @(negedge clk) event_in = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_off_irq got %b want 0", irq); end
        do_read(2'b01, rd, rv);
        checks++; if (rd !== 32'h20) begin errors++; $display("FAIL overflow_bit5 got %h want 20", rd); end
        do_read(2'b10, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL masked_zero got %h want 0", rd); end
        mask = 8'h20;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b want 1", irq); end
        mask = 8'h00;
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL remask_irq got %b want 0", irq); end
        do_write(2'b01, 32'h20);
        do_read(2'b01, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL overflow_w1c got %h want 0", rd); end
        do_write(2'b00, 32'hFF);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_collision();
        @(negedge clk);
        event_in = 8'h02; bus_if.address = 2'b00; bus_if.writedata = 32'h2; bus_if.write = 1'b1;
        @(negedge clk);
        event_in = 8'h00; bus_if.write = 1'b0;
        do_read(2'b00, rd, rv);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL pend_set_wins got %h want 2", rd); end
        @(negedge clk);
        event_in = 8'h02; bus_if.address = 2'b01; bus_if.writedata = 32'h2; bus_if.write = 1'b1;
        @(negedge clk);
        event_in = 8'h00; bus_if.write = 1'b0;
        do_read(2'b01, rd, rv);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ovf_set_wins got %h want 2", rd); end
        @(negedge clk);
        bus_if.address = 2'b00; bus_if.writedata = 32'hFF; bus_if.read = 1'b1; bus_if.write = 1'b1;
        @(negedge clk);
        bus_if.read = 1'b0; bus_if.write = 1'b0;
        checks++; if (bus_if.readdata !== 32'h2) begin errors++; $display("FAIL rw_prewrite got %h want 2", bus_if.readdata); end
        do_read(2'b00, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rw_cleared got %h want 0", rd); end
        @(negedge clk);
        event_in = 8'h01; bus_if.address = 2'b11; bus_if.writedata = 32'h0; bus_if.write = 1'b1;
        @(negedge clk);
        event_in = 8'h00; bus_if.write = 1'b0;
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL evclr_wins got %h want 0", rd); end
        do_write(2'b00, 32'hFF);
        do_write(2'b01, 32'hFF);
    endtask

    task automatic test_back_to_back();
        @(negedge clk) event_in = 8'h08;
        @(negedge clk) event_in = 8'h00;
        bus_if.address = 2'b00; bus_if.read = 1'b1;
        @(negedge clk) bus_if.address = 2'b11;
        checks++; if (bus_if.readdatavalid !== 1'b1 || bus_if.readdata !== 32'h8) begin errors++; $display("FAIL b2b_first got %h/%b want 8/1", bus_if.readdata, bus_if.readdatavalid); end
        @(negedge clk) bus_if.read = 1'b0;
        checks++; if (bus_if.readdatavalid !== 1'b1 || bus_if.readdata !== 32'h1) begin errors++; $display("FAIL b2b_second got %h/%b want 1/1", bus_if.readdata, bus_if.readdatavalid); end
        @(negedge clk);
        checks++; if (bus_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus_if.readdatavalid); end
        do_write(2'b00, 32'hFF);
        do_write(2'b11, 32'h0);
    endtask

    task automatic test_saturation();
        mask = 8'h00;
        repeat (8200) begin
            @(negedge clk) event_in = 8'hFF;
            @(negedge clk) event_in = 8'h00;
        end
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h0000FFFF) begin errors++; $display("FAIL evcount_sat got %h want 0000ffff", rd); end
        do_read(2'b01, rd, rv);
        checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL overflow_all got %h want ff", rd); end
        do_write(2'b11, 32'h0);
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL evcount_clr got %h want 0", rd); end
        do_write(2'b00, 32'hFF);
        do_write(2'b01, 32'hFF);
    endtask

    task automatic test_reset_mid();
        mask = 8'h04;
        @(negedge clk) event_in = 8'h04;
        @(negedge clk) event_in = 8'h00;
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        bus_if.address = 2'b00; bus_if.read = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL mid_read_rdv got %b want 1", bus_if.readdatavalid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0 || bus_if.readdatavalid !== 1'b0 || bus_if.readdata !== 32'h0) begin
            errors++; $display("FAIL async_reset got irq=%b rdv=%b rdata=%h want 0/0/0", irq, bus_if.readdatavalid, bus_if.readdata);
        end
        @(negedge clk) bus_if.read = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a), rd, rv);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_reg%0d got %h want 0", a, rd); end
        end
        @(negedge clk) begin rst_n = 1'b0; event_in = 8'h04; end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) event_in = 8'h00;
        do_read(2'b00, rd, rv);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL held_rise_pending got %h want 4", rd); end
        do_read(2'b11, rd, rv);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL held_rise_count got %h want 1", rd); end
    endtask

    initial begin
        bus_if.address   = 2'b00;
        bus_if.read      = 1'b0;
        bus_if.write     = 1'b0;
        bus_if.writedata = '0;
        test_reset();
        test_event_irq();
        test_holdoff();
        test_overflow();
        test_collision();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
